// File: rtl/fetch_pc_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_controller_if
// Description : Bundle of redirect, branch-prediction, fetch-queue and ICache
//               request signals around the fetch PC controller.
//               master = fetch PC controller, slave = surrounding front end.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_controller_if;
    // Redirect sources
    logic        csr_redir_valid;
    logic [31:0] csr_redir_pc;
    logic        ex_redir_valid;
    logic [31:0] ex_redir_pc;
    logic        pd_redir_valid;
    logic [31:0] pd_redir_pc;
    // Branch prediction for the current fetch PC
    logic        bp_taken;
    logic [31:0] bp_target;
    // Back-pressure
    logic        fq_full;
    logic        ic_ready;
    // Request / control outputs
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        flush_fe;
    logic        flush_if1;
    logic        ic_cancel;
    logic [1:0]  redirect_src;

    modport master (
        input  csr_redir_valid, csr_redir_pc,
        input  ex_redir_valid,  ex_redir_pc,
        input  pd_redir_valid,  pd_redir_pc,
        input  bp_taken,        bp_target,
        input  fq_full,         ic_ready,
        output fetch_valid,     fetch_pc,
        output flush_fe,        flush_if1,
        output ic_cancel,       redirect_src
    );

    modport slave (
        output csr_redir_valid, csr_redir_pc,
        output ex_redir_valid,  ex_redir_pc,
        output pd_redir_valid,  pd_redir_pc,
        output bp_taken,        bp_target,
        output fq_full,         ic_ready,
        input  fetch_valid,     fetch_pc,
        input  flush_fe,        flush_if1,
        input  ic_cancel,       redirect_src
    );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_controller
// Description : Owns the fetch PC. Arbitrates CSR > EX > predecoder redirects
//               against the BTB prediction and issues one fetch address per
//               cycle to the ICache under a valid/ready handshake. A redirect
//               that lands while a request is stalled is parked until that
//               request is accepted, and the accepted response is cancelled.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_controller #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    fetch_pc_controller_if.master  bus
);

    // Redirect source codes double as priority ranks (higher wins).
    localparam logic [1:0] c_SRC_NONE = 2'b00;
    localparam logic [1:0] c_SRC_PD   = 2'b01;
    localparam logic [1:0] c_SRC_EX   = 2'b10;
    localparam logic [1:0] c_SRC_CSR  = 2'b11;

    typedef enum logic [1:0] {
        S_BOOT = 2'b00,
        S_RUN  = 2'b01,
        S_WAIT = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_d;
    logic [31:0] r_pc;
    logic [31:0] w_pc_d;
    logic [31:0] r_pend_pc;
    logic [31:0] w_pend_pc_d;
    logic [1:0]  r_pend_src;
    logic [1:0]  w_pend_src_d;

    logic [1:0]  w_win_src;
    logic [31:0] w_win_pc;
    logic        w_may_overwrite;
    logic [31:0] w_pc_plus4;

    logic        w_fetch_valid;
    logic        w_flush_fe;
    logic        w_flush_if1;
    logic        w_ic_cancel;
    logic [1:0]  w_redirect_src;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Fixed-priority pick of this cycle's redirect winner.
    always_comb begin
        w_win_src = c_SRC_NONE;
        w_win_pc  = '0;
        if (bus.csr_redir_valid) begin
            w_win_src = c_SRC_CSR;
            w_win_pc  = bus.csr_redir_pc;
        end else if (bus.ex_redir_valid) begin
            w_win_src = c_SRC_EX;
            w_win_pc  = bus.ex_redir_pc;
        end else if (bus.pd_redir_valid) begin
            w_win_src = c_SRC_PD;
            w_win_pc  = bus.pd_redir_pc;
        end
    end

    // A parked redirect may only be replaced by one of equal or higher rank,
    // so a late predecoder fix never masks an older EX/CSR redirect.
    assign w_may_overwrite = (w_win_src != c_SRC_NONE) && (w_win_src >= r_pend_src);

    // State, PC and pending-redirect registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_pend_pc  <= '0;
            r_pend_src <= c_SRC_NONE;
        end else begin
            r_state    <= w_state_d;
            r_pc       <= w_pc_d;
            r_pend_pc  <= w_pend_pc_d;
            r_pend_src <= w_pend_src_d;
        end
    end

    // Next-state, next-PC and request/flush outputs.
    always_comb begin
        w_state_d      = r_state;
        w_pc_d         = r_pc;
        w_pend_pc_d    = r_pend_pc;
        w_pend_src_d   = r_pend_src;
        w_fetch_valid  = 1'b0;
        w_flush_fe     = 1'b0;
        w_flush_if1    = 1'b0;
        w_ic_cancel    = 1'b0;
        w_redirect_src = c_SRC_NONE;

        case (r_state)
            S_BOOT: begin
                // One quiet cycle after reset before the first request.
                w_state_d = S_RUN;
            end

            S_RUN: begin
                w_fetch_valid  = ~bus.fq_full;
                w_flush_fe     = bus.csr_redir_valid | bus.ex_redir_valid;
                w_flush_if1    = (w_win_src == c_SRC_PD);
                w_redirect_src = w_win_src;
                if (w_win_src != c_SRC_NONE) begin
                    if (w_fetch_valid && !bus.ic_ready) begin
                        // Request is stuck: keep fetch_pc stable, park target.
                        w_pend_pc_d  = w_win_pc;
                        w_pend_src_d = w_win_src;
                        w_state_d    = S_WAIT;
                    end else begin
                        w_pc_d = w_win_pc;
                    end
                end else if (w_fetch_valid && bus.ic_ready) begin
                    w_pc_d = bus.bp_taken ? bus.bp_target : w_pc_plus4;
                end
            end

            S_WAIT: begin
                // The stalled request must stay presented until accepted.
                w_fetch_valid  = 1'b1;
                w_flush_fe     = bus.csr_redir_valid | bus.ex_redir_valid;
                w_flush_if1    = (w_win_src == c_SRC_PD);
                w_redirect_src = w_win_src;
                if (w_may_overwrite) begin
                    w_pend_pc_d  = w_win_pc;
                    w_pend_src_d = w_win_src;
                end
                if (bus.ic_ready) begin
                    w_ic_cancel  = 1'b1;
                    w_pc_d       = w_may_overwrite ? w_win_pc : r_pend_pc;
                    w_pend_src_d = c_SRC_NONE;
                    w_state_d    = S_RUN;
                end
            end

            default: begin
                w_state_d = S_BOOT;
            end
        endcase
    end

    assign bus.fetch_valid  = w_fetch_valid;
    assign bus.fetch_pc     = r_pc;
    assign bus.flush_fe     = w_flush_fe;
    assign bus.flush_if1    = w_flush_if1;
    assign bus.ic_cancel    = w_ic_cancel;
    assign bus.redirect_src = w_redirect_src;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_controller
// Description : Directed and randomized bench for fetch_pc_controller with a
//               cycle-level reference model of the fetch PC behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_controller;

    localparam logic [31:0] c_RESET_PC = 32'h1c00_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_pc_controller_if bus ();

    fetch_pc_controller #(.RESET_PC(c_RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: "booting" flag, current PC, optional parked redirect.
    bit          m_boot;
    logic [31:0] m_pc;
    bit          m_pending;
    logic [31:0] m_pend_pc;
    int          m_pend_prio;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit cv, input logic [31:0] cpc,
                         input bit ev, input logic [31:0] epc,
                         input bit pv, input logic [31:0] ppc,
                         input bit bt, input logic [31:0] btg,
                         input bit fq, input bit rdy);
        bus.csr_redir_valid = cv;  bus.csr_redir_pc = cpc;
        bus.ex_redir_valid  = ev;  bus.ex_redir_pc  = epc;
        bus.pd_redir_valid  = pv;  bus.pd_redir_pc  = ppc;
        bus.bp_taken        = bt;  bus.bp_target    = btg;
        bus.fq_full         = fq;  bus.ic_ready     = rdy;
    endtask

    task automatic idle(input bit rdy);
        drive(0, '0, 0, '0, 0, '0, 0, '0, 0, rdy);
    endtask

    // Check this cycle's outputs against the model, advance model, clock once.
    // Called at posedge+1 with inputs already applied.
    task automatic cycle();
        int          win;
        logic [31:0] wpc;
        logic [31:0] e_valid, e_ffe, e_fif1, e_cancel, e_src;
        #2;
        win = bus.csr_redir_valid ? 3 : bus.ex_redir_valid ? 2 : bus.pd_redir_valid ? 1 : 0;
        wpc = bus.csr_redir_valid ? bus.csr_redir_pc :
              bus.ex_redir_valid  ? bus.ex_redir_pc  : bus.pd_redir_pc;
        if (m_boot) begin
            e_valid = 0; e_ffe = 0; e_fif1 = 0; e_cancel = 0; e_src = 0;
        end else begin
            e_ffe  = 32'(bus.csr_redir_valid | bus.ex_redir_valid);
            e_fif1 = 32'(win == 1);
            e_src  = 32'(win);
            if (m_pending) begin
                e_valid  = 1;
                e_cancel = 32'(bus.ic_ready);
            end else begin
                e_valid  = 32'(!bus.fq_full);
                e_cancel = 0;
            end
        end
        check_val("fetch_pc",     bus.fetch_pc,          m_pc);
        check_val("fetch_valid",  32'(bus.fetch_valid),  e_valid);
        check_val("flush_fe",     32'(bus.flush_fe),     e_ffe);
        check_val("flush_if1",    32'(bus.flush_if1),    e_fif1);
        check_val("ic_cancel",    32'(bus.ic_cancel),    e_cancel);
        check_val("redirect_src", 32'(bus.redirect_src), e_src);

        if (m_boot) begin
            m_boot = 0;
        end else if (m_pending) begin
            if (win != 0 && win >= m_pend_prio) begin
                m_pend_pc   = wpc;
                m_pend_prio = win;
            end
            if (bus.ic_ready) begin
                m_pc      = m_pend_pc;
                m_pending = 0;
            end
        end else if (win != 0) begin
            if (!bus.fq_full && !bus.ic_ready) begin
                m_pending   = 1;
                m_pend_pc   = wpc;
                m_pend_prio = win;
            end else begin
                m_pc = wpc;
            end
        end else if (!bus.fq_full && bus.ic_ready) begin
            m_pc = bus.bp_taken ? bus.bp_target : m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle (posedge+1), hold it, release at posedge+1.
    task automatic do_reset(input int hold);
        rst = 1'b1;
        #1;
        check_val("rst_fetch_pc",    bus.fetch_pc,         c_RESET_PC);
        check_val("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        check_val("rst_ic_cancel",   32'(bus.ic_cancel),   32'd0);
        check_val("rst_src",         32'(bus.redirect_src), 32'd0);
        m_boot    = 1;
        m_pc      = c_RESET_PC;
        m_pending = 0;
        m_pend_pc = '0;
        m_pend_prio = 0;
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rnd_pc();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 15) == 0) v = 32'hffff_fffc;
        return v;
    endfunction

    initial begin
        idle(1);
        @(posedge clk);
        #1;
        do_reset(2);

        // Sequential fetch from reset.
        idle(1);
        cycle();                                   // BOOT
        check_val("tp_seq0", bus.fetch_pc, 32'h1c00_0000);
        cycle();
        check_val("tp_seq1", bus.fetch_pc, 32'h1c00_0004);
        cycle();
        check_val("tp_seq2", bus.fetch_pc, 32'h1c00_0008);
        cycle();
        cycle();
        check_val("tp_seq4", bus.fetch_pc, 32'h1c00_0010);

        // Taken prediction.
        drive(0, '0, 0, '0, 0, '0, 1, 32'h1c00_0100, 0, 1);
        cycle();
        check_val("tp_bp", bus.fetch_pc, 32'h1c00_0100);

        // All three redirects together.
        drive(1, 32'h1c00_8000, 1, 32'h1c00_0200, 1, 32'h1c00_0300, 0, '0, 0, 1);
        cycle();
        check_val("tp_csr_win", bus.fetch_pc, 32'h1c00_8000);

        // Stall with pd redirect, then ex overwrites the parked target.
        drive(0, '0, 1, 32'h1c00_0040, 0, '0, 0, '0, 0, 1);
        cycle();
        drive(0, '0, 0, '0, 1, 32'h1c00_0080, 0, '0, 0, 0);
        cycle();
        check_val("tp_wait_hold", bus.fetch_pc, 32'h1c00_0040);
        idle(0);
        cycle();
        drive(0, '0, 1, 32'h1c00_0500, 0, '0, 0, '0, 0, 0);
        cycle();
        idle(1);
        cycle();
        check_val("tp_pend_ex", bus.fetch_pc, 32'h1c00_0500);

        // Parked csr is not displaced by ex; fq_full does not drop valid.
        drive(1, 32'h1c00_8000, 0, '0, 0, '0, 0, '0, 0, 0);
        cycle();
        drive(0, '0, 1, 32'h1c00_0600, 0, '0, 0, '0, 0, 0);
        cycle();
        drive(0, '0, 0, '0, 0, '0, 0, '0, 1, 0);
        cycle();
        idle(1);
        cycle();
        check_val("tp_pend_csr", bus.fetch_pc, 32'h1c00_8000);

        // fq_full in RUN holds PC.
        drive(0, '0, 0, '0, 0, '0, 1, 32'h1234_5678, 1, 1);
        cycle();
        check_val("tp_fq_hold", bus.fetch_pc, 32'h1c00_8000);

        // 32-bit wrap.
        drive(0, '0, 1, 32'hffff_fffc, 0, '0, 0, '0, 0, 1);
        cycle();
        idle(1);
        cycle();
        check_val("tp_wrap", bus.fetch_pc, 32'h0000_0000);

        // Reset while a redirect is parked and ic_ready is high.
        drive(0, '0, 0, '0, 1, 32'h1c00_0700, 0, '0, 0, 0);
        cycle();
        idle(1);
        do_reset(1);
        idle(1);
        cycle();
        check_val("tp_rst_boot", bus.fetch_pc, 32'h1c00_0000);
        cycle();
        check_val("tp_rst_seq", bus.fetch_pc, 32'h1c00_0004);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset($urandom_range(1, 2));
            end
            drive($urandom_range(0, 11) == 0, rnd_pc(),
                  $urandom_range(0, 7)  == 0, rnd_pc(),
                  $urandom_range(0, 6)  == 0, rnd_pc(),
                  $urandom_range(0, 3)  == 0, rnd_pc(),
                  $urandom_range(0, 4)  == 0,
                  $urandom_range(0, 9)  <  7);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_pc_controller.md
# fetch_pc_controller

Owns the fetch PC register and sequences the IF1 request toward the ICache. Each cycle it arbitrates between three redirect sources (CSR exception/ertn, EX branch resolution, IF2 predecoder correction) and the BTB prediction. It issues one fetch address per cycle under a valid/ready handshake. A redirect that arrives while an ICache request is presented but not yet accepted is buffered until that request is accepted. The block sits between the BTB/IF2 predecoder and the ICache front end.

## Interface
- RESET_PC, 32'h1c000000, first fetch address after reset

- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- csr_redir_valid  in  1  exception/ertn redirect, highest priority
- csr_redir_pc  in  32  CSR target
- ex_redir_valid  in  1  EX branch mispredict redirect
- ex_redir_pc  in  32  EX target
- pd_redir_valid  in  1  IF2 predecoder flush request, lowest priority
- pd_redir_pc  in  32  predecoder corrected PC
- bp_taken  in  1  BTB predicts taken for current fetch_pc (same cycle)
- bp_target  in  32  BTB target
- fq_full  in  1  fetch queue full; suppresses new requests
- ic_ready  in  1  ICache accepts the presented address
- fetch_valid  out  1  request valid
- fetch_pc  out  32  request address (registered)
- flush_fe  out  1  flush IF1/IF2/fetch queue (CSR or EX redirect)
- flush_if1  out  1  flush IF1 only (predecoder redirect)
- ic_cancel  out  1  response of the request accepted this cycle is wrong-path; drop it
- redirect_src  out  2  winning source this cycle: 00 none, 01 pd, 10 ex, 11 csr

## Operation
- Winner priority: csr > ex > pd. A lower source is ignored in any cycle where a higher one is valid.
- flush_fe = csr_redir_valid | ex_redir_valid. flush_if1 = pd wins. Both are combinational, in all states except BOOT.
- fire = fetch_valid & ic_ready.
- States:
  - BOOT
    - fetch_valid=0, no flushes.
    - Next cycle: RUN.
  - RUN
    - fetch_valid = ~fq_full.
    - If a redirect wins and the request is not stuck (fetch_valid=0 or ic_ready=1): pc_q <= winner pc; stay in RUN.
    - If a redirect wins while fetch_valid=1 and ic_ready=0: pend_pc/pend_src <= winner; go to WAIT. pc_q is held.
    - Otherwise, on fire: pc_q <= bp_taken ? bp_target : pc_q+4.
    - Otherwise: hold.
  - WAIT
    - fetch_valid=1 regardless of fq_full. fetch_pc is held stable.
    - A new redirect overwrites pend only if its priority is ≥ pend_src. A pd redirect never overwrites pending ex/csr; an ex redirect never overwrites pending csr.
    - On ic_ready: ic_cancel=1, pc_q <= pend_pc, go to RUN.
    - If a redirect arrives in the same cycle as ic_ready and may overwrite pend, the new redirect's pc is used.
- PC arithmetic is 32-bit wrap-around: 32'hfffffffc+4 = 0. Low two bits are passed through unchecked.
- Reset values: state=BOOT, pc_q=RESET_PC, pend_pc=0, pend_src=00. All outputs 0 except fetch_pc=RESET_PC.
- Reset asserted mid-WAIT discards the pending redirect; no ic_cancel is issued.

## Timing
- Redirect in RUN at cycle t → fetch_pc = target at t+1; fetch_valid at t+1 per fq_full.
- Redirect in WAIT → target appears on fetch_pc the cycle after ic_ready. ic_cancel is asserted in the ic_ready cycle.
- Sequential fetch: one address per fire. Zero bubbles with ic_ready=1 and fq_full=0.
- bp_taken/bp_target are sampled only on fire with no redirect.
- The first request is presented in the second cycle after rst deasserts.

## Test plan
- Reset release, ic_ready=1, fq_full=0, bp_taken=0:
  - fetch_pc sequence 1c000000 (valid from cycle 2), 1c000004, 1c000008.
  - redirect_src=00; no flushes.
- fire at pc 1c000010 with bp_taken=1, bp_target=1c000100 → next fetch_pc=1c000100.
- Same cycle csr(1c008000), ex(1c000200), pd(1c000300), ic_ready=1:
  - flush_fe=1, flush_if1=0, redirect_src=11.
  - Next fetch_pc=1c008000.
- ic_ready=0 with request at 1c000040, pd redirect to 1c000080:
  - fetch_pc stays 1c000040.
  - Two cycles later ex redirect 1c000500 overwrites pend.
  - ic_ready=1 → ic_cancel=1; next fetch_pc=1c000500.
- In WAIT holding csr pend 1c008000, ex redirect arrives:
  - pend unchanged; flush_fe=1.
  - After accept, fetch_pc=1c008000.
- fq_full=1 in RUN → fetch_valid=0, pc held. Repeat in WAIT → fetch_valid stays 1.
- Assert rst during WAIT → pend cleared; BOOT then fetch_pc=1c000000.
